// File: rtl/mux4_sel_sequencer.sv
// Round-robin select sequencer for a 4:1 mux: drives S1/S0, waits a settle
// time, captures Y and presents it with its channel on a valid/ready port.
module mux4_sel_sequencer #(
  parameter int DWIDTH      = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DWIDTH-1:0] mux_y,
  output logic              S1,
  output logic              S0,
  output logic [3:0]        grant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [1:0]        out_chan,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a sample is transferred on any rising edge where out_valid and
  // out_ready are both high; while out_valid is high the sample and select
  // lines hold steady, and out_ready is ignored while out_valid is low.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [1:0]        r_ptr;
  logic [1:0]        r_sel;
  logic [3:0]        r_grant;
  logic              r_valid;
  logic [DWIDTH-1:0] r_data;
  logic [1:0]        r_chan;
  logic              r_busy;

  logic              w_arb_hit;
  logic [1:0]        w_winner;
  logic [1:0]        w_idx;
  logic              w_handshake;
  logic              w_load;
  logic              w_capture;

  // Search starts just after the last-served channel; the 2-bit add wraps 3+1 to 0.
  always_comb begin
    w_arb_hit = 1'b0;
    w_winner  = r_ptr;
    w_idx     = r_ptr;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_arb_hit && req[w_idx]) begin
        w_arb_hit = 1'b1;
        w_winner  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_handshake = r_valid && out_ready;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_hit) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (w_handshake) begin
          w_load      = w_arb_hit;
          w_state_nxt = w_arb_hit ? ST_SETTLE : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_ptr   <= 2'd3;
      r_sel   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_grant <= '0;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_load) begin
        r_sel <= w_winner;
        r_cnt <= CNT_LOAD;
      end else if (r_state == ST_SETTLE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_data  <= mux_y;
        r_chan  <= r_sel;
        r_valid <= 1'b1;
        r_grant <= 4'b0001 << r_sel;
        r_ptr   <= r_sel;
      end else if (r_state == ST_OUTPUT && w_handshake) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign S1          = r_sel[1];
  assign S0          = r_sel[0];
  assign grant       = r_grant;
  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign out_chan    = r_chan;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux4_sel_sequencer.sv
// Directed testbench for mux4_sel_sequencer; a behavioural 4:1 mux feeds mux_y
// from d_vec so captured data follows the selected channel.
module tb_mux4_sel_sequencer;

  localparam int DWIDTH = 1;
  localparam int HOLD   = 2;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req;
  logic [DWIDTH-1:0] mux_y;
  logic              S1;
  logic              S0;
  logic [3:0]        grant;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic [1:0]        out_chan;
  logic              busy;
  logic [1:0]        dbg_state;
  logic [3:0]        d_vec;

  int n_checks;
  int n_pass;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mux_y = d_vec[{S1, S0}];

  mux4_sel_sequencer #(.DWIDTH(DWIDTH), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mux_y      (mux_y),
    .S1         (S1),
    .S0         (S0),
    .grant      (grant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .busy       (busy),
    .o_dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sel"},   32'({S1, S0}), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] exp_ch;
    n_checks  = 0;
    n_pass    = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    d_vec     = 4'b0000;

    // 1: reset values before any clock edge, then stable over 3 cycles
    #2;
    chk_idle_outputs("rst_async");
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle_outputs("rst_hold");
    end
    rst_n = 1'b1;

    // 2: single request on channel 2, HOLD=2
    req       = 4'b0100;
    d_vec     = 4'b0100;
    out_ready = 1'b1;
    step();
    req = 4'b0000;
    chk("t2_sel_e1",   32'({S1, S0}), 32'd2);
    chk("t2_busy_e1",  32'(busy), 32'd1);
    chk("t2_valid_e1", 32'(out_valid), 32'd0);
    chk("t2_state_e1", 32'(dbg_state), 32'd1);
    step();
    chk("t2_valid_e2", 32'(out_valid), 32'd0);
    step();
    chk("t2_valid_e3", 32'(out_valid), 32'd1);
    chk("t2_chan_e3",  32'(out_chan), 32'd2);
    chk("t2_data_e3",  32'(out_data), 32'd1);
    chk("t2_grant_e3", 32'(grant), 32'b0100);
    chk("t2_state_e3", 32'(dbg_state), 32'd2);
    step();
    chk("t2_valid_e4", 32'(out_valid), 32'd0);
    chk("t2_grant_e4", 32'(grant), 32'd0);
    chk("t2_busy_e4",  32'(busy), 32'd0);
    chk("t2_sel_hold", 32'({S1, S0}), 32'd2);

    // 3: all requests held -> round robin 0,1,2,3,0 with no IDLE bubble
    apply_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    d_vec     = 4'b0101;
    step();
    chk("t3_sel_first", 32'({S1, S0}), 32'd0);
    step();
    step();
    chk("t3_valid_0", 32'(out_valid), 32'd1);
    chk("t3_chan_0",  32'(out_chan), 32'd0);
    chk("t3_data_0",  32'(out_data), 32'(d_vec[0]));
    chk("t3_grant_0", 32'(grant), 32'b0001);
    for (int k = 1; k <= 4; k++) begin
      exp_ch = 2'(k);
      step();
      chk("t3_gap_valid", 32'(out_valid), 32'd0);
      chk("t3_gap_busy",  32'(busy), 32'd1);
      chk("t3_gap_sel",   32'({S1, S0}), 32'(exp_ch));
      step();
      chk("t3_mid_valid", 32'(out_valid), 32'd0);
      step();
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_chan",  32'(out_chan), 32'(exp_ch));
      chk("t3_data",  32'(out_data), 32'(d_vec[exp_ch]));
      chk("t3_grant", 32'(grant), 32'(4'b0001 << exp_ch));
      if (k == 4) req = 4'b0000;
    end
    step();
    chk("t3_end_busy",  32'(busy), 32'd0);
    chk("t3_end_valid", 32'(out_valid), 32'd0);

    // 4: backpressure with mux_y toggling; last served was channel 0
    req       = 4'b0010;
    out_ready = 1'b0;
    d_vec     = 4'b0010;
    step();
    req = 4'b0000;
    chk("t4_sel", 32'({S1, S0}), 32'd1);
    step();
    step();
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_data",  32'(out_data), 32'd1);
    for (int i = 0; i < 5; i++) begin
      d_vec = ~d_vec;
      step();
      chk("t4_bp_valid", 32'(out_valid), 32'd1);
      chk("t4_bp_data",  32'(out_data), 32'd1);
      chk("t4_bp_chan",  32'(out_chan), 32'd1);
      chk("t4_bp_sel",   32'({S1, S0}), 32'd1);
      chk("t4_bp_grant", 32'(grant), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("t4_rel_valid", 32'(out_valid), 32'd0);
    chk("t4_rel_busy",  32'(busy), 32'd0);

    // 5: request dropped during SETTLE still completes
    d_vec = 4'b0010;
    req   = 4'b0010;
    step();
    req = 4'b0000;
    chk("t5_sel", 32'({S1, S0}), 32'd1);
    step();
    chk("t5_settle_state", 32'(dbg_state), 32'd1);
    step();
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_chan",  32'(out_chan), 32'd1);
    chk("t5_data",  32'(out_data), 32'd1);
    chk("t5_grant", 32'(grant), 32'b0010);
    step();
    chk("t5_idle_state", 32'(dbg_state), 32'd0);
    chk("t5_idle_valid", 32'(out_valid), 32'd0);

    // 6: reset pulsed during SETTLE, then channel 3 served
    d_vec = 4'b1000;
    req   = 4'b0100;
    step();
    req = 4'b0000;
    chk("t6_pre_sel", 32'({S1, S0}), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t6_async");
    step();
    chk_idle_outputs("t6_in_rst");
    rst_n = 1'b1;
    req   = 4'b1000;
    step();
    req = 4'b0000;
    chk("t6_sel",       32'({S1, S0}), 32'd3);
    chk("t6_no_valid",  32'(out_valid), 32'd0);
    step();
    chk("t6_no_valid2", 32'(out_valid), 32'd0);
    step();
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_chan",  32'(out_chan), 32'd3);
    chk("t6_data",  32'(out_data), 32'd1);
    chk("t6_grant", 32'(grant), 32'b1000);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
